mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch (IF) and load/store (MEM).
// MEM normally wins contention; IF is forced after MAX_IF_WAIT consecutive MEM grants.
module mem_port_arbiter #(
    parameter int unsigned MAX_IF_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int unsigned CW = (MAX_IF_WAIT > 0) ? $clog2(MAX_IF_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_t;

    state_t          state;
    logic [CW-1:0]   skip_cnt;
    logic            if_valid;
    logic            mem_valid;
    logic            skip_max;
    logic            pick_if;

    // A requester still holds its request during its ready cycle; that cycle must not re-grant.
    always_comb begin
        if_valid  = if_req & ~if_ready;
        mem_valid = (mem_rd | mem_wr) & ~mem_ready;
        skip_max  = (skip_cnt == CW'(MAX_IF_WAIT));
        pick_if   = if_valid & (~mem_valid | skip_max);
        stall_if  = if_req & ~if_ready;
        stall_mem = (mem_rd | mem_wr) & ~mem_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_valid | mem_valid) begin
                        ram_en <= 1'b1;
                        if (pick_if) begin
                            state     <= BUSY_IF;
                            ram_we    <= 1'b0;
                            ram_addr  <= if_addr;
                            ram_wdata <= '0;
                            skip_cnt  <= '0;
                        end else begin
                            state     <= BUSY_MEM;
                            ram_we    <= mem_wr;
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_wdata;
                            if (if_valid && !skip_max)
                                skip_cnt <= skip_cnt + 1'b1;
                        end
                    end
                end
                BUSY_IF: begin
                    if (ram_ack) begin
                        state    <= IDLE;
                        ram_en   <= 1'b0;
                        ram_we   <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= ram_rdata;
                    end
                end
                BUSY_MEM: begin
                    if (ram_ack) begin
                        state     <= IDLE;
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                        mem_ready <= 1'b1;
                        if (!ram_we)
                            mem_rdata <= ram_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store, reset abort, IF starvation.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        stall_if;
    logic        stall_mem;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned mem_pulses = 0;

    mem_port_arbiter #(.MAX_IF_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (mem_ready === 1'b1) mem_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Acts as the RAM: waits (bounded) for ram_en, checks the issued command stays stable,
    // acks after wait_cyc extra cycles, and returns in the owner's ready cycle.
    task automatic serve(input int unsigned wait_cyc, input logic [31:0] data,
                         input logic [31:0] exp_addr, input logic exp_we,
                         input logic [31:0] exp_wdata, output int unsigned we_cycles);
        int unsigned t = 0;
        we_cycles = 0;
        while (ram_en !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("grant_ram_en", {31'b0, ram_en}, 32'd1);
        check("grant_addr", ram_addr, exp_addr);
        check("grant_we", {31'b0, ram_we}, {31'b0, exp_we});
        if (exp_we) check("grant_wdata", ram_wdata, exp_wdata);
        for (int i = 0; i < int'(wait_cyc); i++) begin
            if (ram_we === 1'b1) we_cycles++;
            @(negedge clk);
            check("hold_en", {31'b0, ram_en}, 32'd1);
            check("hold_addr", ram_addr, exp_addr);
            if (exp_we) check("hold_wdata", ram_wdata, exp_wdata);
        end
        if (ram_we === 1'b1) we_cycles++;
        ram_ack   = 1'b1;
        ram_rdata = data;
        @(negedge clk);
        ram_ack   = 1'b0;
        ram_rdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wc;
        int unsigned c0;
        int unsigned p0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0; ram_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ram_en", {31'b0, ram_en}, 32'd0);
        check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_readys", {30'b0, if_ready, mem_ready}, 32'd0);
        rst = 1'b0;

        // single fetch, minimum latency
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; c0 = cyc;
        serve(0, 32'h8C01_0004, 32'h40, 1'b0, 32'h0, wc);
        check("fetch_latency", cyc - c0, 32'd2);
        check("fetch_ready", {31'b0, if_ready}, 32'd1);
        check("fetch_rdata", if_rdata, 32'h8C01_0004);
        check("fetch_stall_in_ready", {31'b0, stall_if}, 32'd0);
        @(negedge clk);
        check("fetch_pulse_one", {31'b0, if_ready}, 32'd0);
        check("fetch_no_reissue", {31'b0, ram_en}, 32'd0);
        check("fetch_rdata_hold", if_rdata, 32'h8C01_0004);
        if_req = 1'b0;

        // contention: MEM first, IF granted in mem_ready's cycle
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; mem_rd = 1'b1; mem_addr = 32'h10;
        serve(0, 32'h1111_2222, 32'h10, 1'b0, 32'h0, wc);
        check("cont_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("cont_mem_rdata", mem_rdata, 32'h1111_2222);
        check("cont_stall_if", {31'b0, stall_if}, 32'd1);
        check("cont_stall_mem", {31'b0, stall_mem}, 32'd0);
        @(negedge clk);
        check("cont_if_grant_en", {31'b0, ram_en}, 32'd1);
        check("cont_if_grant_addr", ram_addr, 32'h100);
        check("cont_mem_pulse_one", {31'b0, mem_ready}, 32'd0);
        mem_rd = 1'b0;
        serve(0, 32'h3333_4444, 32'h100, 1'b0, 32'h0, wc);
        check("cont_if_ready", {31'b0, if_ready}, 32'd1);
        check("cont_if_rdata", if_rdata, 32'h3333_4444);
        check("cont_mem_rdata_hold", mem_rdata, 32'h1111_2222);
        @(negedge clk);
        check("cont_no_reissue", {31'b0, ram_en}, 32'd0);
        if_req = 1'b0;

        // store with 3 wait cycles
        @(negedge clk);
        mem_wr = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
        serve(3, 32'h5555_5555, 32'h20, 1'b1, 32'hDEAD_BEEF, wc);
        check("store_we_cycles", wc, 32'd4);
        check("store_ready", {31'b0, mem_ready}, 32'd1);
        check("store_rdata_kept", mem_rdata, 32'h1111_2222);
        @(negedge clk);
        check("store_pulse_one", {31'b0, mem_ready}, 32'd0);
        check("store_en_off", {30'b0, ram_en, ram_we}, 32'd0);
        mem_wr = 1'b0;

        // rd and wr together behave as a store
        @(negedge clk);
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h24; mem_wdata = 32'h0BAD_F00D;
        serve(0, 32'h7777_7777, 32'h24, 1'b1, 32'h0BAD_F00D, wc);
        check("rdwr_rdata_kept", mem_rdata, 32'h1111_2222);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;

        // reset while BUSY_MEM, then a late ack
        @(negedge clk);
        mem_rd = 1'b1; mem_addr = 32'h44;
        @(negedge clk);
        check("rstmid_granted", {31'b0, ram_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rd = 1'b0;
        check("rstmid_en", {30'b0, ram_en, ram_we}, 32'd0);
        check("rstmid_addr", ram_addr, 32'd0);
        check("rstmid_ready", {31'b0, mem_ready}, 32'd0);
        ram_ack = 1'b1; ram_rdata = 32'h0000_0BAD;
        @(negedge clk);
        ram_ack = 1'b0;
        check("late_ack_ready", {31'b0, mem_ready}, 32'd0);
        check("late_ack_rdata", mem_rdata, 32'd0);
        check("late_ack_en", {31'b0, ram_en}, 32'd0);
        @(negedge clk);
        check("late_ack_ready2", {31'b0, mem_ready}, 32'd0);
        if_req = 1'b1; if_addr = 32'h300; c0 = cyc;
        serve(0, 32'h0303_0303, 32'h300, 1'b0, 32'h0, wc);
        check("post_rst_latency", cyc - c0, 32'd2);
        check("post_rst_rdata", if_rdata, 32'h0303_0303);
        @(negedge clk);
        if_req = 1'b0;

        // starvation: IF withdrawn only during MEM's ready cycles so MEM keeps winning contention
        @(negedge clk);
        p0 = mem_pulses;
        mem_rd = 1'b1; mem_addr = 32'h80; if_req = 1'b1; if_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            serve(0, 32'hA000_0000 + 32'(k), 32'h80, 1'b0, 32'h0, wc);
            check("starve_mem_ready", {31'b0, mem_ready}, 32'd1);
            if_req = 1'b0;
            @(negedge clk);
            if_req = 1'b1;
        end
        serve(0, 32'hCAFE_0001, 32'h200, 1'b0, 32'h0, wc);
        check("starve_mem_count", mem_pulses - p0, 32'd4);
        check("starve_if_ready", {31'b0, if_ready}, 32'd1);
        check("starve_if_rdata", if_rdata, 32'hCAFE_0001);
        mem_rd = 1'b0; if_req = 1'b0;
        @(negedge clk);
        mem_rd = 1'b1; if_req = 1'b1;
        // skip count cleared by the IF grant, so MEM wins again
        serve(0, 32'hB0B0_B0B0, 32'h80, 1'b0, 32'h0, wc);
        check("skip_clear_mem_rdata", mem_rdata, 32'hB0B0_B0B0);
        mem_rd = 1'b0; if_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
